// File: rtl/game_state_ctrl.sv
// game_state_ctrl: registered collision/restart control between obstacle/jump generators and display mux.
// Optional GAME_GRACE_EN: post-reset/restart grace period that blocks collisions and blinks the dino.
module game_state_ctrl #(
   parameter int DINO_COL    = 1,
   parameter int COLL_HOLD   = 2,
   parameter int DEB_TICKS   = 20,
   parameter int FLASH_TICKS = 500,
   parameter int MUX_DIV     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       button,
   input  logic [7:0] dino_row,
   input  logic [7:0] ob_col0,
   input  logic [7:0] ob_col1,
   input  logic [7:0] ob_col2,
   input  logic [1:0] ob_h0,
   input  logic [1:0] ob_h1,
   input  logic [1:0] ob_h2,
   output logic       game_over,
   output logic       restart,
   output logic       run_en,
   output logic [1:0] disp_sel,
   output logic       flash
);
   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_HIT  = 2'd1;
   localparam logic [1:0] S_OVER = 2'd2;
   localparam logic [7:0] DINO       = 8'(DINO_COL);
   localparam logic [3:0] COLL       = 4'(COLL_HOLD);
   localparam logic [7:0] DEB_LAST   = 8'(DEB_TICKS - 1);
   localparam logic [9:0] FLASH_LAST = 10'(FLASH_TICKS - 1);
   localparam logic [9:0] BLINK_LAST = 10'd249;
   localparam logic [9:0] MUX_LAST   = 10'(MUX_DIV - 1);
   localparam logic [9:0] GRACE_INIT = 10'd300;

   if (FLASH_TICKS < 1 || FLASH_TICKS > 1023) begin : g_bad_flash
      $error("FLASH_TICKS must be within 1..1023");
   end

   logic [1:0] r_sync;
   logic       r_deb;
   logic       r_deb_q;
   logic [7:0] r_deb_cnt;
   logic [1:0] r_state;
   logic [3:0] r_pcnt;
   logic [9:0] r_tmr;
   logic [9:0] r_mux_cnt;
   logic       r_sel;
   logic       r_blink;
   logic       r_restart;
   logic       w_press;
   logic       w_hit0;
   logic       w_hit1;
   logic       w_hit2;
   logic       w_overlap;
   logic       w_coll;
   logic       w_restart_go;
   logic       w_grace;

   function automatic logic [7:0] f_mask(input logic [1:0] h);
      return (h == 2'd0) ? 8'h00 : (h == 2'd1) ? 8'h01 : (h == 2'd2) ? 8'h03 : 8'h07;
   endfunction

   always_comb begin
      w_hit0       = (ob_col0 == DINO) && (ob_col0 != 8'hFF) && |(dino_row & f_mask(ob_h0));
      w_hit1       = (ob_col1 == DINO) && (ob_col1 != 8'hFF) && |(dino_row & f_mask(ob_h1));
      w_hit2       = (ob_col2 == DINO) && (ob_col2 != 8'hFF) && |(dino_row & f_mask(ob_h2));
      w_overlap    = w_hit0 | w_hit1 | w_hit2;
      w_press      = r_deb & ~r_deb_q;
      w_coll       = (r_state == S_RUN) && (r_pcnt >= COLL);
      w_restart_go = (r_state == S_OVER) && w_press;
   end

   // Debounced level only moves after DEB_TICKS consecutive ticks of a differing synced value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync    <= '0;
         r_deb     <= 1'b0;
         r_deb_q   <= 1'b0;
         r_deb_cnt <= '0;
      end else begin
         r_sync  <= {r_sync[0], button};
         r_deb_q <= r_deb;
         if (r_sync[1] == r_deb) begin
            r_deb_cnt <= '0;
         end else if (tick) begin
            r_deb_cnt <= (r_deb_cnt == DEB_LAST) ? 8'd0 : r_deb_cnt + 8'd1;
            if (r_deb_cnt == DEB_LAST) r_deb <= r_sync[1];
         end
      end
   end

`ifdef GAME_GRACE_EN
   logic [9:0] r_grace;
   always_ff @(posedge clk) begin
      if (reset || w_restart_go) r_grace <= GRACE_INIT;
      else if (tick && r_state == S_RUN && r_grace != 10'd0) r_grace <= r_grace - 10'd1;
   end
   assign w_grace = |r_grace;
`else
   assign w_grace = 1'b0;
`endif

   // r_tmr is shared: flash duration in HIT, blink period in OVER.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_RUN;
         r_pcnt    <= '0;
         r_tmr     <= '0;
         r_mux_cnt <= '0;
         r_sel     <= 1'b0;
         r_blink   <= 1'b0;
         r_restart <= 1'b0;
      end else begin
         r_restart <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (w_coll) begin
                  r_state <= S_HIT;
                  r_tmr   <= '0;
                  r_pcnt  <= '0;
               end else if (tick) begin
                  r_pcnt    <= (w_overlap && !w_grace) ? ((r_pcnt == 4'hF) ? r_pcnt : r_pcnt + 4'd1) : 4'd0;
                  r_mux_cnt <= (r_mux_cnt == MUX_LAST) ? 10'd0 : r_mux_cnt + 10'd1;
                  if (r_mux_cnt == MUX_LAST) r_sel <= ~r_sel;
               end
            end
            S_HIT: begin
               if (tick) begin
                  r_tmr <= (r_tmr == FLASH_LAST) ? 10'd0 : r_tmr + 10'd1;
                  if (r_tmr == FLASH_LAST) begin
                     r_state <= S_OVER;
                     r_blink <= 1'b1;
                  end
               end
            end
            S_OVER: begin
               if (w_restart_go) begin
                  r_state   <= S_RUN;
                  r_restart <= 1'b1;
                  r_sel     <= 1'b0;
                  r_mux_cnt <= '0;
                  r_pcnt    <= '0;
               end else if (tick) begin
                  r_tmr <= (r_tmr == BLINK_LAST) ? 10'd0 : r_tmr + 10'd1;
                  if (r_tmr == BLINK_LAST) r_blink <= ~r_blink;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   always_comb begin
      game_over = (r_state != S_RUN);
      run_en    = (r_state == S_RUN);
      restart   = r_restart;
      disp_sel  = (r_state == S_RUN) ? {1'b0, r_sel} : 2'd2;
      flash     = (r_state == S_HIT) ? 1'b1 : (r_state == S_OVER) ? r_blink : w_grace;
   end
endmodule
